nrisc_wishbone_master: RTL
==========================

Name: nrisc_wishbone_master

Overview:
- Wishbone master stage directly upstream of the NRISC-Aurora Wishbone slave.
- Converts single-word CPU load/store requests into Wishbone classic cycles.
- Handles ACK, ERR and RETRY terminations, with bounded retry and back-off.
- Returns read data and completion status to the CPU core; one outstanding transaction at a time.

Parameters:
- TAM, 16: address/data/select width; must match the slave's TAM.
- MAX_RETRY, 3: number of RETRY terminations tolerated before the request completes with error.
- RETRY_GAP, 2: idle cycles with STROBE low between a RETRY and the re-issue.
- TIMEOUT, 255: cycles in BUS before abort. Used only with WSHMSTR_TIMEOUT_EN.

Ports:
- WSHMSTR_CLKIN  in  1  single clock; all logic is on the rising edge.
- WSHMSTR_RSTIN  in  1  synchronous, active-high reset.
- CPU_REQ  in  1  request strobe; sampled only in IDLE.
- CPU_WREN  in  1  1 = write, 0 = read.
- CPU_LOCK  in  1  request bus lock for this and following locked transfers.
- CPU_ADDR  in  TAM  address.
- CPU_WDATA  in  TAM  write data.
- CPU_SEL  in  TAM  select mask, passed through unchanged.
- CPU_TGA  in  8  address tag.
- CPU_TGC  in  8  cycle tag.
- CPU_TGD  in  8  write-data tag.
- CPU_RDATA  out  TAM  read data, held until the next completed read.
- CPU_RTGD  out  8  read-data tag, held the same way.
- CPU_DONE  out  1  one-cycle completion pulse.
- CPU_ERR  out  1  qualifies CPU_DONE: transaction failed.
- CPU_TOUT  out  1  qualifies CPU_ERR: failure was a timeout.
- CPU_BUSY  out  1  high from acceptance until the CPU_DONE cycle, inclusive.
- WSHMSTR_ADDROUT  out  TAM  to slave ADDRIN.
- WSHMSTR_DATAOUT  out  TAM  to slave DATAIN.
- WSHMSTR_SEL  out  TAM  to slave SEL.
- WSHMSTR_WREN  out  1  to slave WREN.
- WSHMSTR_STROBE  out  1  combined CYC/STB.
- WSHMSTR_LOCKOUT  out  1  to slave LOCKIN.
- WSHMSTR_TGA  out  8  to slave TGA.
- WSHMSTR_TGC  out  8  to slave TGC.
- WSHMSTR_TGDOUT  out  8  to slave TGDIN.
- WSHMSTR_DATAIN  in  TAM  from slave DATAOUT.
- WSHMSTR_TGDIN  in  8  from slave TGDOUT.
- WSHMSTR_ACK  in  1  from slave ACK.
- WSHMSTR_ERRIN  in  1  from slave ERROUT.
- WSHMSTR_RETRY  in  1  from slave RETRY.

Behaviour:
- All outputs are registered.
- Reset (RSTIN sampled high at an edge): every output goes to 0, state = IDLE, retry and timeout counters = 0.
- Reset mid-transaction: STROBE is low after that edge, the transaction is discarded and no CPU_DONE is produced.
- IDLE: if CPU_REQ = 1, latch all CPU_* request fields and set CPU_BUSY. Next cycle STROBE = 1 and state = BUS.
- BUS: bus outputs are held stable. Terminations are sampled each edge with priority ACK > ERRIN > RETRY.
- ACK: STROBE drops. On a read, CPU_RDATA/CPU_RTGD latch DATAIN/TGDIN. CPU_DONE = 1, CPU_ERR = 0 next cycle. State returns to IDLE.
- ERRIN: STROBE drops. CPU_DONE = 1 and CPU_ERR = 1 next cycle. CPU_RDATA is unchanged.
- RETRY: STROBE drops and the retry count increments.
  - If the new count equals MAX_RETRY: complete as ERRIN.
  - Otherwise go to BACKOFF for RETRY_GAP cycles, then return to BUS with STROBE = 1 and identical fields.
- DONE cycle: CPU_BUSY = 1, STROBE = 0. The next cycle is IDLE; counters are cleared there.
- Latency: acceptance at edge 0 and STROBE high after edge 1. Zero-wait ACK sampled at edge 2 gives CPU_DONE after edge 2. A new request is accepted at earliest edge 3.
- CPU_REQ is ignored while CPU_BUSY = 1; there is no queueing.
- Lock:
  - LOCKOUT = latched CPU_LOCK from acceptance onward.
  - It stays high through IDLE after an ACK-completed locked transfer.
  - It clears when a request with CPU_LOCK = 0 is accepted, or on any error completion.

Optional Feature:
- WSHMSTR_TIMEOUT_EN defined: a counter runs in BUS and resets on re-entry from BACKOFF.
  - When it reaches TIMEOUT with no termination, STROBE drops.
  - The request then completes with CPU_ERR = 1 and CPU_TOUT = 1.
  - A termination arriving in the same cycle as the timeout wins.
- WSHMSTR_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; CPU_TOUT is tied to 0.

Decomposition:
- Package nrisc_wshb_pkg holds:
  - state encoding: IDLE, BUS, BACKOFF, DONE;
  - tag width 8;
  - default TAM, MAX_RETRY, RETRY_GAP, TIMEOUT constants, shared with the slave.
- One sub-module, nrisc_wshb_cnt: a loadable down-counter with a zero flag.
  - Instanced for the back-off count.
  - Instanced again for the timeout count when WSHMSTR_TIMEOUT_EN is defined.

Test Plan:
- Zero-wait read: CPU_REQ with ADDR 0x0010; slave ACKs in the first STROBE cycle with DATAIN 0xBEEF. Expect CPU_DONE after edge 2, CPU_RDATA = 0xBEEF, CPU_ERR = 0.
- Wait-state write: WDATA 0x1234, ACK after 4 cycles. Expect STROBE and bus fields stable all 4 cycles, one CPU_DONE pulse, and CPU_RDATA unchanged.
- Retry: slave RETRYs twice, then ACKs. Expect STROBE low for 2 cycles after each RETRY and success. With 3 RETRYs: CPU_DONE with CPU_ERR = 1 and 3 STROBE bursts total.
- Priority and error: ACK and ERRIN asserted together gives success; ERRIN alone gives CPU_ERR = 1; a locked transfer followed by an error clears LOCKOUT.
- Reset mid-BUS: assert RSTIN during a wait state. Expect all outputs 0 after that edge and no CPU_DONE. With WSHMSTR_TIMEOUT_EN and TIMEOUT = 8 and no ACK, expect CPU_ERR = 1 and CPU_TOUT = 1 after 8 BUS cycles.

Source files
------------

// File: rtl/nrisc_wshb_pkg.sv
// rtl/nrisc_wshb_pkg.sv - shared Wishbone master/slave constants and state encoding
// Default widths and retry/timeout limits must agree with the NRISC-Aurora slave.
package nrisc_wshb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_DONE    = 2'd3
    } wshb_state_e;

    localparam int TAG_W          = 8;
    localparam int CNT_W          = 16;
    localparam int RETRY_W        = 8;
    localparam int WSHB_TAM       = 16;
    localparam int WSHB_MAX_RETRY = 3;
    localparam int WSHB_RETRY_GAP = 2;
    localparam int WSHB_TIMEOUT   = 255;

endpackage

// File: rtl/nrisc_wshb_cnt.sv
// rtl/nrisc_wshb_cnt.sv - loadable down-counter with zero flag
// Load wins over decrement; the count saturates at zero.
module nrisc_wshb_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/nrisc_wishbone_master.sv
// rtl/nrisc_wishbone_master.sv - single-outstanding CPU to Wishbone classic master
// Optional bus watchdog enabled by defining WSHMSTR_TIMEOUT_EN.
module nrisc_wishbone_master
    import nrisc_wshb_pkg::*;
#(
    parameter int TAM       = WSHB_TAM,
    parameter int MAX_RETRY = WSHB_MAX_RETRY,
    parameter int RETRY_GAP = WSHB_RETRY_GAP,
    parameter int TIMEOUT   = WSHB_TIMEOUT
) (
    input  logic             WSHMSTR_CLKIN,
    input  logic             WSHMSTR_RSTIN,
    input  logic             CPU_REQ,
    input  logic             CPU_WREN,
    input  logic             CPU_LOCK,
    input  logic [TAM-1:0]   CPU_ADDR,
    input  logic [TAM-1:0]   CPU_WDATA,
    input  logic [TAM-1:0]   CPU_SEL,
    input  logic [TAG_W-1:0] CPU_TGA,
    input  logic [TAG_W-1:0] CPU_TGC,
    input  logic [TAG_W-1:0] CPU_TGD,
    output logic [TAM-1:0]   CPU_RDATA,
    output logic [TAG_W-1:0] CPU_RTGD,
    output logic             CPU_DONE,
    output logic             CPU_ERR,
    output logic             CPU_TOUT,
    output logic             CPU_BUSY,
    output logic [TAM-1:0]   WSHMSTR_ADDROUT,
    output logic [TAM-1:0]   WSHMSTR_DATAOUT,
    output logic [TAM-1:0]   WSHMSTR_SEL,
    output logic             WSHMSTR_WREN,
    output logic             WSHMSTR_STROBE,
    output logic             WSHMSTR_LOCKOUT,
    output logic [TAG_W-1:0] WSHMSTR_TGA,
    output logic [TAG_W-1:0] WSHMSTR_TGC,
    output logic [TAG_W-1:0] WSHMSTR_TGDOUT,
    input  logic [TAM-1:0]   WSHMSTR_DATAIN,
    input  logic [TAG_W-1:0] WSHMSTR_TGDIN,
    input  logic             WSHMSTR_ACK,
    input  logic             WSHMSTR_ERRIN,
    input  logic             WSHMSTR_RETRY
);

    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]   GAP_LOAD    = (RETRY_GAP > 0) ? CNT_W'(RETRY_GAP - 1) : '0;
    localparam logic [CNT_W-1:0]   TO_LOAD     = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    wshb_state_e        state_q;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               busy_q, done_q, err_q, tout_q;
    logic               strobe_q, lock_q, wren_q;
    logic [TAM-1:0]     addr_q, wdata_q, sel_q, rdata_q;
    logic [TAG_W-1:0]   tga_q, tgc_q, tgd_q, rtgd_q;

    logic               idle_like, in_bus, retry_to_backoff;
    logic               bo_load, bo_dec, bo_zero;
    logic [CNT_W-1:0]   bo_val;
    logic               term_tout;

    // DONE behaves like IDLE at its closing edge so a new request can be taken there.
    always_comb begin
        idle_like        = (state_q == ST_IDLE) || (state_q == ST_DONE);
        in_bus           = (state_q == ST_BUS);
        retry_d          = retry_q + RETRY_W'(1);
        retry_to_backoff = in_bus && !WSHMSTR_ACK && !WSHMSTR_ERRIN && WSHMSTR_RETRY
                           && (retry_d != MAX_RETRY_C);
        bo_load          = idle_like || retry_to_backoff;
        bo_val           = retry_to_backoff ? GAP_LOAD : '0;
        bo_dec           = (state_q == ST_BACKOFF);
    end

    nrisc_wshb_cnt #(.W(CNT_W)) u_backoff_cnt (
        .clk_i      (WSHMSTR_CLKIN),
        .rst_i      (WSHMSTR_RSTIN),
        .load_i     (bo_load),
        .load_val_i (bo_val),
        .dec_i      (bo_dec),
        .zero_o     (bo_zero)
    );

`ifdef WSHMSTR_TIMEOUT_EN
    logic             to_load, to_zero;
    logic [CNT_W-1:0] to_val;

    // Rearmed during every BACKOFF cycle, so each STROBE burst gets a full window.
    always_comb begin
        to_load   = !in_bus;
        to_val    = (state_q == ST_BACKOFF) ? TO_LOAD : '0;
        term_tout = in_bus && to_zero && !WSHMSTR_ACK && !WSHMSTR_ERRIN && !WSHMSTR_RETRY;
    end

    nrisc_wshb_cnt #(.W(CNT_W)) u_timeout_cnt (
        .clk_i      (WSHMSTR_CLKIN),
        .rst_i      (WSHMSTR_RSTIN),
        .load_i     (to_load),
        .load_val_i (to_val),
        .dec_i      (in_bus),
        .zero_o     (to_zero)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TO_LOAD;
    assign term_tout      = 1'b0;
`endif

    always_ff @(posedge WSHMSTR_CLKIN) begin
        if (WSHMSTR_RSTIN) begin
            state_q  <= ST_IDLE;
            retry_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
            strobe_q <= 1'b0;
            lock_q   <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
            tga_q    <= '0;
            tgc_q    <= '0;
            tgd_q    <= '0;
            rtgd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    retry_q  <= '0;
                    err_q    <= 1'b0;
                    tout_q   <= 1'b0;
                    strobe_q <= 1'b0;
                    busy_q   <= CPU_REQ;
                    state_q  <= ST_IDLE;
                    if (CPU_REQ) begin
                        wren_q  <= CPU_WREN;
                        lock_q  <= CPU_LOCK;
                        addr_q  <= CPU_ADDR;
                        wdata_q <= CPU_WDATA;
                        sel_q   <= CPU_SEL;
                        tga_q   <= CPU_TGA;
                        tgc_q   <= CPU_TGC;
                        tgd_q   <= CPU_TGD;
                        state_q <= ST_BACKOFF;
                    end
                end
                ST_BACKOFF: begin
                    if (bo_zero) begin
                        strobe_q <= 1'b1;
                        state_q  <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (WSHMSTR_ACK) begin
                        strobe_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        state_q  <= ST_DONE;
                        if (!wren_q) begin
                            rdata_q <= WSHMSTR_DATAIN;
                            rtgd_q  <= WSHMSTR_TGDIN;
                        end
                    end else if (WSHMSTR_ERRIN) begin
                        strobe_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        lock_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else if (WSHMSTR_RETRY) begin
                        strobe_q <= 1'b0;
                        retry_q  <= retry_d;
                        if (retry_d == MAX_RETRY_C) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            lock_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_BACKOFF;
                        end
                    end else if (term_tout) begin
                        strobe_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        tout_q   <= 1'b1;
                        lock_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign CPU_RDATA       = rdata_q;
    assign CPU_RTGD        = rtgd_q;
    assign CPU_DONE        = done_q;
    assign CPU_ERR         = err_q;
    assign CPU_TOUT        = tout_q;
    assign CPU_BUSY        = busy_q;
    assign WSHMSTR_ADDROUT = addr_q;
    assign WSHMSTR_DATAOUT = wdata_q;
    assign WSHMSTR_SEL     = sel_q;
    assign WSHMSTR_WREN    = wren_q;
    assign WSHMSTR_STROBE  = strobe_q;
    assign WSHMSTR_LOCKOUT = lock_q;
    assign WSHMSTR_TGA     = tga_q;
    assign WSHMSTR_TGC     = tgc_q;
    assign WSHMSTR_TGDOUT  = tgd_q;

endmodule
